// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory (mem_*) between fetch (i_*) and data (d_*) with bounded data priority, flush drop and stallF/stallM
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DPRIO_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          flush,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stallF,
  output logic          stallM
);
  localparam int SW = $clog2(DPRIO_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(DPRIO_LIMIT);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic          own_d_q, own_d_d, drop_q, drop_d, we_q, we_d, elig, grant_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
  assign elig    = i_req & ~flush;
  assign grant_d = d_req & (~elig | (streak_q < LIM));
  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    drop_d   = drop_q;
    we_d     = we_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: begin
        streak_d = (grant_d & elig) ? streak_q + SW'(1) : '0;
        if (grant_d | elig) begin
          state_d = grant_d ? DBUSY : IBUSY;
          own_d_d = grant_d;
          drop_d  = 1'b0;
          we_d    = grant_d & d_we;
          addr_d  = grant_d ? d_addr : i_addr;
          wdata_d = grant_d ? d_wdata : wdata_q;
        end
      end
      IBUSY, DBUSY: begin
        drop_d = drop_q | (flush & ~own_d_q);
        if (mem_ready) begin
          state_d  = DONE;
          irdata_d = (~own_d_q & ~drop_d) ? mem_rdata : irdata_q;
          drdata_d = (own_d_q & ~we_q) ? mem_rdata : drdata_q;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      drop_q   <= 1'b0;
      we_q     <= 1'b0;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      drop_q   <= drop_d;
      we_q     <= we_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end
  assign mem_req   = (state_q == IBUSY) | (state_q == DBUSY);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = irdata_q;
  assign d_rdata   = drdata_q;
  assign i_ack     = (state_q == DONE) & ~own_d_q & ~drop_q;
  assign d_ack     = (state_q == DONE) & own_d_q;
  assign stallF    = i_req & ~i_ack;
  assign stallM    = d_req & ~d_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model of mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, LIM = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic i_req = 1'b0, flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic i_ack, d_ack, mem_req, mem_we, stallF, stallM;
  int total = 0, bad = 0;
  int lat_cfg = 1, cnt = 0, lat = 1;
  bit noise = 0, force_rdy = 0;
  logic [DW-1:0] last_i, last_d;

  mem_arbiter #(.AW(AW), .DW(DW), .DPRIO_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .flush(flush), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stallF(stallF), .stallM(stallM));

  always #5 clk = ~clk;

  // advance one cycle, then let the memory responder react to the new mem_req
  task automatic tick();
    @(posedge clk);
    #1;
    if (force_rdy) mem_ready = 1'b1;
    else if (!mem_req) begin
      cnt = 0;
      mem_ready = noise && ($urandom_range(0, 3) == 0);
    end else begin
      cnt++;
      if (cnt == 1) lat = (lat_cfg > 0) ? lat_cfg : $urandom_range(1, 4);
      if (cnt == lat) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
      end else mem_ready = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL rst_acks got=%b%b exp=00", i_ack, d_ack); end
    total++; if (i_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    logic [DW-1:0] w;
    lat_cfg = 1;
    i_req = 1'b1;
    i_addr = 32'h0040_0000;
    #1;
    total++; if (stallF !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL sf_c0 got stallF=%b req=%b exp 1/0", stallF, mem_req); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_we !== 1'b0) begin bad++; $display("FAIL sf_c1 got req=%b addr=%h we=%b exp 1/00400000/0", mem_req, mem_addr, mem_we); end
    total++; if (i_ack !== 1'b0 || stallF !== 1'b1) begin bad++; $display("FAIL sf_c1_ack got ack=%b stallF=%b exp 0/1", i_ack, stallF); end
    w = mem_rdata;
    tick();
    total++; if (mem_req !== 1'b0 || i_ack !== 1'b1 || stallF !== 1'b0) begin bad++; $display("FAIL sf_c2 got req=%b ack=%b stallF=%b exp 0/1/0", mem_req, i_ack, stallF); end
    total++; if (i_rdata !== w) begin bad++; $display("FAIL sf_rdata got=%h exp=%h", i_rdata, w); end
    i_req = 1'b0;
    tick();
    total++; if (i_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL sf_c3 got ack=%b req=%b exp 0/0", i_ack, mem_req); end
  endtask

  task automatic test_priority();
    lat_cfg = 1;
    i_req = 1'b1;
    i_addr = 32'h0040_0004;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1000_0010;
    tick();
    total++; if (mem_addr !== 32'h1000_0010 || mem_we !== 1'b0 || stallF !== 1'b1) begin bad++; $display("FAIL pr_dfirst got addr=%h we=%b stallF=%b exp 10000010/0/1", mem_addr, mem_we, stallF); end
    last_d = mem_rdata;
    tick();
    total++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || stallM !== 1'b0) begin bad++; $display("FAIL pr_dack got d=%b i=%b stallM=%b exp 1/0/0", d_ack, i_ack, stallM); end
    total++; if (d_rdata !== last_d) begin bad++; $display("FAIL pr_drdata got=%h exp=%h", d_rdata, last_d); end
    d_req = 1'b0;
    tick();
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0004) begin bad++; $display("FAIL pr_igrant got req=%b addr=%h exp 1/00400004", mem_req, mem_addr); end
    last_i = mem_rdata;
    tick();
    total++; if (i_ack !== 1'b1 || i_rdata !== last_i) begin bad++; $display("FAIL pr_iack got ack=%b data=%h exp 1/%h", i_ack, i_rdata, last_i); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    lat_cfg = 3;
    d_req = 1'b1;
    d_we = 1'b1;
    d_wdata = 32'hDEAD_BEEF;
    d_addr = 32'h1000_0020;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1000_0020) begin bad++; $display("FAIL st_hold%0d got req=%b we=%b wd=%h addr=%h exp 1/1/deadbeef/10000020", k, mem_req, mem_we, mem_wdata, mem_addr); end
    end
    tick();
    total++; if (d_ack !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL st_ack got ack=%b req=%b exp 1/0", d_ack, mem_req); end
    total++; if (d_rdata !== last_d) begin bad++; $display("FAIL st_rdata got=%h exp=%h", d_rdata, last_d); end
    d_req = 1'b0;
    d_we = 1'b0;
    tick();
    total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL st_pulse got=%b exp=0", d_ack); end
  endtask

  task automatic test_flush();
    bit got = 0;
    lat_cfg = 3;
    i_req = 1'b1;
    i_addr = 32'h0040_0008;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0008) begin bad++; $display("FAIL fl_grant got req=%b addr=%h exp 1/00400008", mem_req, mem_addr); end
    flush = 1'b1;
    i_addr = 32'h0040_0100;
    tick();
    flush = 1'b0;
    tick();
    tick();
    total++; if (i_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fl_noack got ack=%b req=%b exp 0/0", i_ack, mem_req); end
    total++; if (i_rdata !== last_i) begin bad++; $display("FAIL fl_rdata got=%h exp=%h", i_rdata, last_i); end
    tick();
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0100) begin bad++; $display("FAIL fl_regrant got req=%b addr=%h exp 1/00400100", mem_req, mem_addr); end
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (i_ack === 1'b1) begin
        got = 1;
        last_i = mem_rdata;
        total++; if (i_rdata !== last_i) begin bad++; $display("FAIL fl_newdata got=%h exp=%h", i_rdata, last_i); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL fl_newack got=none exp=ack within 20 cycles"); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_streak();
    logic [9:0] seq = '0;
    int n = 0;
    logic prev = 1'b0;
    lat_cfg = 0;
    i_req = 1'b1;
    i_addr = 32'h0040_0200;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1000_0100;
    for (int k = 0; k < 300 && n < 10; k++) begin
      tick();
      if (mem_req && !prev) begin
        seq[n] = mem_addr[28];
        n++;
      end
      prev = mem_req;
      if (d_ack) d_addr = d_addr + 4;
      if (i_ack) i_addr = i_addr + 4;
    end
    total++; if (n != 10) begin bad++; $display("FAIL sk_count got=%0d exp=10", n); end
    total++; if (seq !== 10'b01111_01111) begin bad++; $display("FAIL sk_order got=%b exp=0111101111", seq); end
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset_mid();
    lat_cfg = 4;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1000_0030;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b exp=1", mem_req); end
    tick();
    reset = 1'b1;
    d_req = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL rm_mem got req=%b we=%b addr=%h wd=%h exp zeros", mem_req, mem_we, mem_addr, mem_wdata); end
    total++; if (d_rdata !== '0 || i_rdata !== '0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin bad++; $display("FAIL rm_out got d=%h i=%h acks=%b%b exp zeros", d_rdata, i_rdata, d_ack, i_ack); end
    reset = 1'b0;
    force_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (d_ack !== 1'b0 || i_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rm_late%0d got acks=%b%b req=%b exp 00/0", k, d_ack, i_ack, mem_req); end
    end
    force_rdy = 0;
    tick();
  endtask

  task automatic test_random();
    bit busy = 0, ack_due = 0, own_d = 0, drop = 0, wr = 0, eia = 0, eda = 0, nia, nda, elig, gd;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] wd = '0, eir = '0, edr = '0;
    int streak = 0;
    noise = 1;
    lat_cfg = 0;
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    flush = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (eia || !i_req) begin
        i_req = $urandom_range(0, 1);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush) i_addr = $urandom & 32'hFFFF_FFFC;
      if (eda || !d_req) begin
        d_req = $urandom_range(0, 1);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end
      #1;
      total++; if (stallF !== (i_req & ~eia) || stallM !== (d_req & ~eda)) begin bad++; $display("FAIL rnd_stall@%0d got=%b%b exp=%b%b", k, stallF, stallM, i_req & ~eia, d_req & ~eda); end
      nia = 0;
      nda = 0;
      if (ack_due) ack_due = 0;
      else if (busy) begin
        if (flush && !own_d) drop = 1;
        if (mem_ready) begin
          busy = 0;
          ack_due = 1;
          if (own_d) begin
            nda = 1;
            if (!wr) edr = mem_rdata;
          end else if (!drop) begin
            nia = 1;
            eir = mem_rdata;
          end
        end
      end else begin
        elig = i_req && !flush;
        gd = d_req && (!elig || streak < LIM);
        if (gd || elig) begin
          busy = 1;
          own_d = gd;
          drop = 0;
          a = gd ? d_addr : i_addr;
          wr = gd && d_we;
          wd = d_wdata;
        end
        streak = (gd && elig) ? streak + 1 : 0;
      end
      eia = nia;
      eda = nda;
      tick();
      total++; if (mem_req !== busy) begin bad++; $display("FAIL rnd_req@%0d got=%b exp=%b", k, mem_req, busy); end
      if (busy) begin
        total++; if (mem_addr !== a || mem_we !== wr || (wr && mem_wdata !== wd)) begin bad++; $display("FAIL rnd_mem@%0d got=%h/%b/%h exp=%h/%b/%h", k, mem_addr, mem_we, mem_wdata, a, wr, wd); end
      end
      total++; if (i_ack !== eia || d_ack !== eda) begin bad++; $display("FAIL rnd_ack@%0d got=%b%b exp=%b%b", k, i_ack, d_ack, eia, eda); end
      total++; if (i_rdata !== eir || d_rdata !== edr) begin bad++; $display("FAIL rnd_rdata@%0d got=%h/%h exp=%h/%h", k, i_rdata, d_rdata, eir, edr); end
    end
    noise = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_store();
    test_flush();
    test_streak();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
